// File: rtl/dpram_arb_pkg.sv
// Shared types for the dual-port RAM arbiter.
package dpram_arb_pkg;

    typedef enum logic {
        CL_A = 1'b0,
        CL_B = 1'b1
    } client_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    function automatic client_e other_client(input client_e c);
        return (c == CL_A) ? CL_B : CL_A;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
// The priority pointer always moves to the requester that did not win.
module rr_arb2
    import dpram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    client_e prio;

    // grant decode: a lone requester always wins, a tie goes to prio
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (prio == CL_A) ? 2'b01 : 2'b10;
        end
    end

    // priority pointer follows every grant to the other side
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= CL_A;
        end else if (gnt[0]) begin
            prio <= other_client(CL_A);
        end else if (gnt[1]) begin
            prio <= other_client(CL_B);
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares a 1W/1R RAM between requesters A and B: zero-fill sweep after reset,
// independent round-robin for the write and read ports, read response routing
// and same-cycle write-to-read forwarding.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  ST_INIT | sweeping zeros into every RAM address, no traffic taken
//  ST_RUN  | arbitrating requests onto the RAM ports
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_data,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef struct packed {
        logic              valid;
        client_e           owner;
        logic              fwd;
        logic [DATA_W-1:0] fwd_data;
    } rsp_pipe_t;

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] sweep;
    logic [ADDR_W-1:0] sweep_nxt;
    logic              init_act;
    logic              run_act;
    logic [1:0]        wr_req;
    logic [1:0]        rd_req;
    logic [1:0]        wr_gnt;
    logic [1:0]        rd_gnt;
    logic              fwd_hit;
    rsp_pipe_t         rsp;
    logic [DATA_W-1:0] rsp_data_sel;

    // state and sweep address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if (INIT_EN) begin
                state <= ST_INIT;
            end else begin
                state <= ST_RUN;
            end
            sweep <= '0;
        end else begin
            state <= state_nxt;
            sweep <= sweep_nxt;
        end
    end

    // sweep one address per cycle, leave INIT after the last address
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        if (state == ST_INIT) begin
            sweep_nxt = sweep + 1'b1;
            if (sweep == ADDR_W'(DEPTH - 1)) begin
                state_nxt = ST_RUN;
            end
        end
    end

    // Qualifying with rst keeps every output at 0 the moment reset asserts,
    // rather than waiting for the state register to settle.
    assign init_act = rst && (state == ST_INIT);
    assign run_act  = rst && (state == ST_RUN);

    assign wr_req = {b_req_valid &  b_req_we, a_req_valid &  a_req_we} & {2{run_act}};
    assign rd_req = {b_req_valid & ~b_req_we, a_req_valid & ~a_req_we} & {2{run_act}};

    rr_arb2 u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .gnt (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt)
    );

    assign a_req_ready = wr_gnt[0] | rd_gnt[0];
    assign b_req_ready = wr_gnt[1] | rd_gnt[1];

    // RAM port muxing from the sweep or the winning requester
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_data_in = '0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        if (init_act) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = sweep;
        end else if (wr_gnt[0]) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = a_req_addr;
            ram_data_in = a_req_wdata;
        end else if (wr_gnt[1]) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = b_req_addr;
            ram_data_in = b_req_wdata;
        end
        if (rd_gnt[0]) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = a_req_addr;
        end else if (rd_gnt[1]) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = b_req_addr;
        end
    end

    // The RAM returns the pre-write value on a same-address collision, so the
    // written data is captured here and substituted in the response.
    assign fwd_hit = ram_wr_en && ram_rd_en && (ram_wr_addr == ram_rd_addr);

    // one-deep response pipe: owner tag plus forwarded data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp <= '0;
        end else begin
            rsp.valid    <= ram_rd_en;
            rsp.owner    <= rd_gnt[1] ? CL_B : CL_A;
            rsp.fwd      <= fwd_hit;
            rsp.fwd_data <= ram_data_in;
        end
    end

    assign rsp_data_sel = rsp.fwd ? rsp.fwd_data : ram_data_out;

    assign a_rsp_valid = rsp.valid && (rsp.owner == CL_A);
    assign b_rsp_valid = rsp.valid && (rsp.owner == CL_B);
    assign a_rsp_data  = a_rsp_valid ? rsp_data_sel : '0;
    assign b_rsp_data  = b_rsp_valid ? rsp_data_sel : '0;

endmodule
